// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble converter: one input bit per clock, DONE pulses BIN_W+1 clocks after START is accepted.
// No queueing: START while BUSY is dropped, and BCD/OVF hold the previous result until the next DONE.
module bin2bcd_seq #(
    parameter int BIN_W  = 16,
    parameter int DIGITS = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  START,
    input  logic [BIN_W-1:0]      BIN,
    output logic                  BUSY,
    output logic                  DONE,
    output logic [4*DIGITS-1:0]   BCD,
    output logic                  OVF
);
    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);

    function automatic longint unsigned pow10(input int n);
        longint unsigned r;
        r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    localparam longint unsigned MAX_VAL = pow10(DIGITS) - 1;
    localparam logic [CNT_W-1:0] LAST_IT = CNT_W'(BIN_W - 1);

    typedef enum logic [1:0] {IDLE, CONV, FIN} state_t;

    state_t             state_q, state_d;
    logic [BIN_W-1:0]   shift_q, shift_d;
    logic [BCD_W-1:0]   scratch_q, scratch_d;
    logic [BCD_W-1:0]   adj;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               pend_ovf_q, pend_ovf_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic               ovf_q, ovf_d;
    logic               bin_big;

    // Pre-saturating the input keeps every scratch nibble <= 9, so no nibble can overflow.
    assign bin_big = 64'(BIN) > MAX_VAL;

    always_comb begin
        adj = scratch_q;
        for (int d = 0; d < DIGITS; d++) begin
            if (scratch_q[4*d +: 4] >= 4'd5)
                adj[4*d +: 4] = scratch_q[4*d +: 4] + 4'd3;
        end
    end

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        scratch_d  = scratch_q;
        cnt_d      = cnt_q;
        pend_ovf_d = pend_ovf_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        bcd_d      = bcd_q;
        ovf_d      = ovf_q;
        unique case (state_q)
            IDLE: begin
                if (START) begin
                    state_d    = CONV;
                    shift_d    = bin_big ? BIN_W'(MAX_VAL) : BIN;
                    scratch_d  = '0;
                    cnt_d      = '0;
                    pend_ovf_d = bin_big;
                    busy_d     = 1'b1;
                end
            end
            CONV: begin
                scratch_d = BCD_W'({adj, shift_q[BIN_W-1]});
                shift_d   = {shift_q[BIN_W-2:0], 1'b0};
                cnt_d     = cnt_q + 1'b1;
                if (cnt_q == LAST_IT)
                    state_d = FIN;
            end
            FIN: begin
                bcd_d   = scratch_q;
                ovf_d   = pend_ovf_q;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            scratch_q  <= '0;
            cnt_q      <= '0;
            pend_ovf_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            bcd_q      <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            scratch_q  <= scratch_d;
            cnt_q      <= cnt_d;
            pend_ovf_q <= pend_ovf_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            bcd_q      <= bcd_d;
            ovf_q      <= ovf_d;
        end
    end

    assign BUSY = busy_q;
    assign DONE = done_q;
    assign BCD  = bcd_q;
    assign OVF  = ovf_q;

endmodule
